// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared state encoding and step limit for the shift sequencer
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    // Largest amount the 2-bit shift unit can apply in one pass.
    localparam int MAX_STEP = 3;

endpackage

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - combinational 2-bit-shamt logical right shifter
module shift_unit #(
    parameter int N = 8
) (
    input  logic [1:0]   shamt,
    input  logic [N-1:0] dataa,
    output logic [N-1:0] dataout
);

    assign dataout = dataa >> shamt;

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle front end that splits a shift amount into steps of at most 3
module shift_sequencer #(
    parameter int N     = 8,
    parameter int AMT_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [AMT_W-1:0] in_amount,
    output logic [1:0]       shamt,
    output logic [N-1:0]     dataa,
    input  logic [N-1:0]     dataout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_zero,
    output logic             busy
);

    import shift_sequencer_pkg::*;

    seq_state_t       state;
    logic [N-1:0]     acc;
    logic [AMT_W-1:0] remaining;
    logic [1:0]       step;

    always_comb begin
        step = remaining[1:0];
        if (remaining > AMT_W'(MAX_STEP)) begin
            step = 2'(MAX_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acc       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc       <= in_data;
                        remaining <= in_amount;
                        state     <= (in_amount == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc       <= dataout;
                    remaining <= remaining - AMT_W'(step);
                    // The last step consumes whatever is left.
                    if (remaining == AMT_W'(step)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign shamt     = (state == ST_SHIFT) ? step : 2'd0;
    assign dataa     = acc;
    assign out_data  = acc;
    assign out_zero  = (acc == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer with the shift unit beside it
module tb_shift_sequencer;

    localparam int N     = 8;
    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [AMT_W-1:0] in_amount;
    logic [1:0]       shamt;
    logic [N-1:0]     dataa;
    logic [N-1:0]     dataout;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_zero;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    shift_sequencer #(.N(N), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .shamt     (shamt),
        .dataa     (dataa),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    shift_unit #(.N(N)) u_shift (
        .shamt   (shamt),
        .dataa   (dataa),
        .dataout (dataout)
    );

    // Reference: shift right one bit at a time, amt times.
    function automatic logic [N-1:0] model(input logic [N-1:0] d, input int amt);
        logic [N-1:0] r;
        r = d;
        for (int i = 0; i < amt; i++) r = {1'b0, r[N-1:1]};
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input string tag, input logic [N-1:0] d, input int amt);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = AMT_W'(amt);
        exp_q.push_back(model(d, amt));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, compare against the scoreboard, then accept.
    task automatic collect(input string tag, input int max_cycles);
        logic [N-1:0] exp;
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_seen"}, out_valid, 1'b1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_out_data"}, out_data, exp);
        check({tag, "_out_zero"}, out_zero, (exp == '0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, out_valid, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amount = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_zero", out_zero, 1'b1);
        check("rst_shamt", shamt, 2'd0);
        check("rst_dataa", dataa, 8'h00);
        check("rst_busy", busy, 1'b0);

        // Amount 0 goes straight to DONE.
        send("amt0", 8'hA5, 0);
        check("amt0_valid_next", out_valid, 1'b1);
        check("amt0_shamt", shamt, 2'd0);
        collect("amt0", 2);

        // Amount 7: steps 3,3,1 then DONE on the 4th cycle.
        send("amt7", 8'hFF, 7);
        check("amt7_s1", shamt, 2'd3);
        check("amt7_s1_nv", out_valid, 1'b0);
        @(negedge clk);
        check("amt7_s2", shamt, 2'd3);
        @(negedge clk);
        check("amt7_s3", shamt, 2'd1);
        check("amt7_s3_nv", out_valid, 1'b0);
        @(negedge clk);
        check("amt7_done", out_valid, 1'b1);
        check("amt7_done_shamt", shamt, 2'd0);
        collect("amt7", 1);

        // Amount 3 (one step) vs amount 4 (two steps).
        send("amt3", 8'h81, 3);
        check("amt3_s1", shamt, 2'd3);
        @(negedge clk);
        check("amt3_done", out_valid, 1'b1);
        collect("amt3", 1);
        send("amt4", 8'h81, 4);
        check("amt4_s1", shamt, 2'd3);
        @(negedge clk);
        check("amt4_s2", shamt, 2'd1);
        check("amt4_s2_nv", out_valid, 1'b0);
        @(negedge clk);
        check("amt4_done", out_valid, 1'b1);
        collect("amt4", 1);

        // Back-pressure: DONE held for 10 cycles with stable output.
        send("bp", 8'hC3, 5);
        for (int i = 0; i < 4 && out_valid !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_data", out_data, model(8'hC3, 5));
            check("bp_hold_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        collect("bp", 1);
        check("bp_idle_after", in_ready, 1'b1);

        // Reset on the second SHIFT cycle discards the operation.
        send("rst", 8'hFF, 7);
        @(negedge clk);
        check("rst_mid_shift", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        check("rstm_in_ready", in_ready, 1'b1);
        check("rstm_out_valid", out_valid, 1'b0);
        check("rstm_acc", dataa, 8'h00);
        check("rstm_busy", busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("rstm_no_valid", out_valid, 1'b0);
            @(negedge clk);
        end

        // in_valid held during SHIFT/DONE is ignored until IDLE.
        send("hold1", 8'hF0, 6);
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        in_amount = 3'd4;
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready_busy", in_ready, 1'b0);
            @(negedge clk);
        end
        check("hold_done", out_valid, 1'b1);
        check("hold_done_in_ready", in_ready, 1'b0);
        collect("hold1", 1);
        check("hold_idle_in_ready", in_ready, 1'b1);
        exp_q.push_back(model(8'h0F, 4));
        @(negedge clk);
        in_valid = 1'b0;
        check("hold2_accepted", busy, 1'b1);
        collect("hold2", 4);
        check("hold2_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
